audio_dac_serializer: RTL
=========================

Name: audio_dac_serializer

Overview:
- Downstream stage of the wavetable synth voice.
- Generates the codec bit clock (bclk) and left/right clock (daclrck) from clk_50, and consumes the voice's 16-bit sample output.
- Serializes each sample MSB-first on dacdat, identical on both channels (mono), at 50 MHz / 1024 ≈ 48.83 kHz.
- bclk and daclrck also feed back to the wavetable voice, which reads and latches its samples on them.

Parameters:
- DATA_W, 16, sample width in bits.
- I2S_MODE, 0: 0 = left-justified; 1 = I2S, with data delayed one bclk after each daclrck edge.
- BCLK_DIV_LOG2, 3: bclk half-period is 2^BCLK_DIV_LOG2 clk_50 cycles (default bclk = 3.125 MHz).
- SLOT_BITS, 32: bclk periods per channel. Frame length FRAME = 2 * SLOT_BITS * 2^(BCLK_DIV_LOG2+1) = 1024 cycles.

Ports:
- clk_50, input, 1, system clock (50 MHz).
- ar, input, 1, reset: one clock; reset is asynchronous and active-high.
- sample_in, input, DATA_W, sample from the wavetable voice; only sampled at the capture point.
- mute, input, 1, forces the captured sample to zero.
- bclk, output, 1, codec bit clock.
- daclrck, output, 1, codec left/right clock; high = left channel.
- dacdat, output, 1, serial data to the codec.
- frame_strobe, output, 1, one-cycle pulse at frame start.

Behaviour:
- Frame counter
  - cnt is log2(FRAME) bits wide, free-running 0..FRAME-1, and wraps to 0.
  - Reset value is FRAME-1, so the first edge after reset release wraps cnt to 0 and produces a clean daclrck rising edge.
- Output registers
  - All outputs are registered flops; no combinational gating on any output.
  - Each edge loads the decode of cnt_next (the value cnt takes on that edge).
  - bclk = cnt_next[BCLK_DIV_LOG2].
  - daclrck = 1 when cnt_next < FRAME/2, else 0.
  - frame_strobe = (cnt_next == 0).
- Reset: bclk, daclrck, dacdat, frame_strobe = 0; hold register = 0; shift register = 0; cnt = FRAME-1. Reset takes effect immediately, without a clock edge, including mid-frame.
- Bit slots
  - Slot index b = cnt_next within the half-frame, divided by 2^(BCLK_DIV_LOG2+1); range 0..SLOT_BITS-1.
  - dacdat changes only on slot boundaries, which coincide with bclk falling edges.
  - dacdat is stable for a full bclk period; the codec samples it on bclk rising edges, mid-slot.
- Left-justified (I2S_MODE=0): slot b < DATA_W carries bit sample[DATA_W-1-b]; slots DATA_W..SLOT_BITS-1 carry 0.
- I2S (I2S_MODE=1): slot 0 carries 0; slot b in 1..DATA_W carries sample[DATA_W-b]; remaining slots carry 0.
- Capture point: the edge where cnt_next == FRAME/2 (daclrck falling).
  - hold <= mute ? 0 : sample_in.
  - sample_in has been stable for 512 cycles at this point, because the voice updates on daclrck rise.
- Shift register loads
  - The shift register loads from hold on the edges where cnt_next == 0 and cnt_next == FRAME/2.
  - At FRAME/2, the load uses the old hold value (same-edge update), so left and right carry the same sample in every frame.
- Latency: a sample_in value present while cnt == FRAME/2-1 appears on dacdat at the start of the next frame. That is cnt_next = 0 in left-justified mode, or one bclk later in I2S mode.
- mute: has no effect on the frame in progress; it takes effect at the next capture point only.
- Never stalls: there is no handshake and no backpressure. A sample_in change between capture points is ignored until the next capture point.

Test Plan:
1. Reset release, defaults -> first edge: daclrck=1, frame_strobe=1, bclk=0. bclk period is 16 clk with 50% duty; daclrck period is 1024 clk (512 high / 512 low); frame_strobe recurs every 1024 clk.
2. I2S_MODE=0, sample_in=16'hA5C3 held constant -> from frame 2 on, each channel's slots 0..15 read 1010_0101_1100_0011 on bclk rising edges, slots 16..31 read 0, and left equals right.
3. I2S_MODE=1, sample_in=16'hA5C3 -> slot 0 reads 0, slots 1..16 read A5C3 MSB-first, slots 17..31 read 0, on both channels.
4. Capture timing: sample_in=16'h1234 until the capture edge, then 16'h8001 from the next cycle -> the next frame transmits 1234 on both channels; 8001 appears one frame later.
5. mute=1 across a capture point with sample_in=16'hFFFF -> the following frame's dacdat is all 0. Deasserting mute restores FFFF one frame after the next capture.
6. ar pulsed high mid-frame (cnt≈700) with no clk edge -> all outputs read 0 during reset. After release, the first edge gives daclrck=1 and frame_strobe=1, and the hold register reads 0 until the next capture.

Source files
------------

// File: rtl/audio_dac_serializer.sv
// Codec serializer for the wavetable voice: generates bclk/daclrck from clk_50
// and shifts each captured 16-bit sample out MSB-first on dacdat, the same
// sample on both channels.
module audio_dac_serializer #(
  parameter int DATA_W        = 16,
  parameter int I2S_MODE      = 0,
  parameter int BCLK_DIV_LOG2 = 3,
  parameter int SLOT_BITS     = 32
) (
  input  logic              clk_50,
  input  logic              ar,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              mute,
  output logic              bclk,
  output logic              daclrck,
  output logic              dacdat,
  output logic              frame_strobe
);

  localparam int SLOT_LOG2 = BCLK_DIV_LOG2 + 1;
  localparam int SLOT_CYC  = 2 ** SLOT_LOG2;
  localparam int FRAME     = 2 * SLOT_BITS * SLOT_CYC;
  localparam int CNT_W     = $clog2(FRAME);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FRAME / 2);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] load_val;
  logic              load_bit;
  logic              at_start;
  logic              at_half;
  logic              slot_edge;

  // Next counter value and the edge decodes every register below keys off.
  // Left-justified puts the MSB in slot 0; I2S sends a zero there and starts
  // the MSB one slot later, so the whole word stays in the shift register.
  always_comb begin
    cnt_next  = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    at_start  = (cnt_next == '0);
    at_half   = (cnt_next == CNT_HALF);
    slot_edge = (cnt_next[SLOT_LOG2-1:0] == '0);
    if (I2S_MODE != 0) begin
      load_val = hold;
      load_bit = 1'b0;
    end else begin
      load_val = {hold[DATA_W-2:0], 1'b0};
      load_bit = hold[DATA_W-1];
    end
  end

  // Free-running frame counter; resets to the last count so the first edge
  // after reset starts a fresh frame with a clean daclrck rise.
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) cnt <= CNT_MAX;
    else    cnt <= cnt_next;
  end

  // Codec clocks and frame marker, registered from the decode of cnt_next.
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      bclk         <= 1'b0;
      daclrck      <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      bclk         <= cnt_next[BCLK_DIV_LOG2];
      daclrck      <= (cnt_next < CNT_HALF);
      frame_strobe <= at_start;
    end
  end

  // Capture the voice sample as daclrck falls, half a frame after the voice
  // updated it, so sample_in has long settled.
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar)           hold <= '0;
    else if (at_half) hold <= mute ? '0 : sample_in;
  end

  // Load at each channel start (the half-frame load still sees the old hold,
  // keeping left and right identical), then shift one bit per slot boundary.
  always_ff @(posedge clk_50 or posedge ar) begin
    if (ar) begin
      shreg  <= '0;
      dacdat <= 1'b0;
    end else if (at_start || at_half) begin
      shreg  <= load_val;
      dacdat <= load_bit;
    end else if (slot_edge) begin
      shreg  <= {shreg[DATA_W-2:0], 1'b0};
      dacdat <= shreg[DATA_W-1];
    end
  end

endmodule
